regfile_arbiter: RTL and testbench

Two-client arbiter that shares the 16 x 32 register file's single write port and single read port between two requesters, e.g. an instruction-execute unit (client 0) and a debug/DMA unit (client 1). The write port and the read port are arbitrated independently, each with its own round-robin pointer, so one client can read while the other writes in the same cycle. Read data is registered and returned one cycle after grant, with write-first forwarding on same-cycle address collisions. The block sits between the clients and the register file and drives all of the register file's ports.

---
 rtl/regfile_arbiter_if.sv | 48 ++++
 rtl/regfile_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// Client-side and register-file-side signals of the two-client register file arbiter.
// The master modport is the side that raises requests and owns the register file;
// the slave modport is the arbiter itself.
interface regfile_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  // client 0
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;
  // client 1
  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;
  // register file ports
  logic                  rf_write;
  logic [ADDR_WIDTH-1:0] rf_wrAddr;
  logic [DATA_WIDTH-1:0] rf_wrData;
  logic [ADDR_WIDTH-1:0] rf_rdAddrA;
  logic [DATA_WIDTH-1:0] rf_rdDataA;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  rf_write, rf_wrAddr, rf_wrData, rf_rdAddrA,
    output rf_rdDataA
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output rf_write, rf_wrAddr, rf_wrData, rf_rdAddrA,
    input  rf_rdDataA
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-client arbiter for a register file with one write port and one read port.
// Each port has its own round-robin pointer, so one client may read while the
// other writes in the same cycle. Read data is registered per client, with
// write-first forwarding when the granted read and write hit the same address.
module regfile_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input logic              clk,
  input logic              reset,
  regfile_arbiter_if.slave bus
);

  logic [1:0]            req;
  logic [1:0]            we;
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [DATA_WIDTH-1:0] wdata [2];

  logic [1:0]            wrCand;
  logic [1:0]            rdCand;
  logic [1:0]            wrGnt;
  logic [1:0]            rdGnt;

  logic                  wrPtrReg;
  logic                  rdPtrReg;

  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [DATA_WIDTH-1:0] wrData;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [DATA_WIDTH-1:0] rdDataNext;

  assign req      = {bus.req1, bus.req0};
  assign we       = {bus.we1, bus.we0};
  assign addr[0]  = bus.addr0;
  assign addr[1]  = bus.addr1;
  assign wdata[0] = bus.wdata0;
  assign wdata[1] = bus.wdata1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      logic                  rvalidReg;
      logic [DATA_WIDTH-1:0] rdataReg;

      assign wrCand[gi] = req[gi] & we[gi];
      assign rdCand[gi] = req[gi] & ~we[gi];

      // A candidate wins when it is alone on the port or the pointer favours it.
      // Grants are forced low while reset is asserted.
      assign wrGnt[gi] = ~reset & wrCand[gi] & (~wrCand[1-gi] | (wrPtrReg == 1'(gi)));
      assign rdGnt[gi] = ~reset & rdCand[gi] & (~rdCand[1-gi] | (rdPtrReg == 1'(gi)));

      // Capture read data for this client one edge after its read grant.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rvalidReg <= 1'b0;
          rdataReg  <= '0;
        end else begin
          rvalidReg <= rdGnt[gi];
          if (rdGnt[gi]) begin
            rdataReg <= rdDataNext;
          end
        end
      end
    end
  endgenerate

  // Steer the granted client's fields onto the register file ports; idle ports drive 0.
  always_comb begin
    wrAddr = '0;
    wrData = '0;
    rdAddr = '0;
    if (wrGnt[0]) begin
      wrAddr = addr[0];
      wrData = wdata[0];
    end else if (wrGnt[1]) begin
      wrAddr = addr[1];
      wrData = wdata[1];
    end
    if (rdGnt[0]) begin
      rdAddr = addr[0];
    end else if (rdGnt[1]) begin
      rdAddr = addr[1];
    end
  end

  // Write-first: a same-cycle write to the read address supplies the read value.
  assign rdDataNext = ((|wrGnt) && (|rdGnt) && (rdAddr == wrAddr)) ? wrData : bus.rf_rdDataA;

  // Round-robin pointers: after a grant the other client becomes favoured.
  // Granting client 0 sets the pointer to 1 and granting client 1 sets it to 0,
  // so the next pointer value is simply the client-0 grant bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtrReg <= 1'b0;
      rdPtrReg <= 1'b0;
    end else begin
      if (|wrGnt) begin
        wrPtrReg <= wrGnt[0];
      end
      if (|rdGnt) begin
        rdPtrReg <= rdGnt[0];
      end
    end
  end

  assign bus.gnt0       = wrGnt[0] | rdGnt[0];
  assign bus.gnt1       = wrGnt[1] | rdGnt[1];
  assign bus.rvalid0    = g_client[0].rvalidReg;
  assign bus.rvalid1    = g_client[1].rvalidReg;
  assign bus.rdata0     = g_client[0].rdataReg;
  assign bus.rdata1     = g_client[1].rdataReg;
  assign bus.rf_write   = |wrGnt;
  assign bus.rf_wrAddr  = wrAddr;
  assign bus.rf_wrData  = wrData;
  assign bus.rf_rdAddrA = rdAddr;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a small register file model answers the
// read port and absorbs the write port; expected values are hand-computed.
module tb_regfile_arbiter;

  logic clk;
  logic reset;
  logic rfClear;
  logic [31:0] rfMem [16];

  int nCompared;
  int nMismatched;

  regfile_arbiter_if bus ();

  regfile_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file: synchronous write, combinational read
  always @(posedge clk) begin
    if (rfClear) begin
      for (int i = 0; i < 16; i++) rfMem[i] <= 32'h0;
    end else if (bus.rf_write) begin
      rfMem[bus.rf_wrAddr] <= bus.rf_wrData;
    end
  end
  assign bus.rf_rdDataA = rfMem[bus.rf_rdAddrA];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
  endtask

  task automatic idle1();
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic op0(input logic w, input logic [3:0] a, input logic [31:0] d);
    bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic op1(input logic w, input logic [3:0] a, input logic [31:0] d);
    bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic resetPulse();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset   = 1'b1;
    rfClear = 1'b1;
    idle0();
    idle1();
    op0(1'b1, 4'd5, 32'h1234_5678);
    cyc();
    cyc();
    rfClear = 1'b0;

    // ---- reset state: requests present but nothing granted
    checkEq("rst_gnt0", {31'b0, bus.gnt0}, 32'h0);
    checkEq("rst_rf_write", {31'b0, bus.rf_write}, 32'h0);
    checkEq("rst_rvalid0", {31'b0, bus.rvalid0}, 32'h0);
    checkEq("rst_rdata0", bus.rdata0, 32'h0);
    checkEq("rst_rdata1", bus.rdata1, 32'h0);
    idle0();
    reset = 1'b0;
    cyc();

    // ---- write r5 then read it back
    op0(1'b1, 4'd5, 32'hDEAD_BEEF);
    #1;
    checkEq("wr_gnt0", {31'b0, bus.gnt0}, 32'h1);
    checkEq("wr_gnt1", {31'b0, bus.gnt1}, 32'h0);
    checkEq("wr_rf_write", {31'b0, bus.rf_write}, 32'h1);
    checkEq("wr_rf_wrAddr", {28'b0, bus.rf_wrAddr}, 32'h5);
    checkEq("wr_rf_wrData", bus.rf_wrData, 32'hDEAD_BEEF);
    cyc();
    op0(1'b0, 4'd5, 32'h0);
    #1;
    checkEq("rd_gnt0", {31'b0, bus.gnt0}, 32'h1);
    checkEq("rd_rf_rdAddrA", {28'b0, bus.rf_rdAddrA}, 32'h5);
    checkEq("rd_idle_rf_write", {31'b0, bus.rf_write}, 32'h0);
    checkEq("rd_idle_rf_wrAddr", {28'b0, bus.rf_wrAddr}, 32'h0);
    cyc();
    idle0();
    checkEq("rd_rvalid0", {31'b0, bus.rvalid0}, 32'h1);
    checkEq("rd_rdata0", bus.rdata0, 32'hDEAD_BEEF);
    checkEq("rd_rvalid1", {31'b0, bus.rvalid1}, 32'h0);
    cyc();
    checkEq("rd_rvalid0_pulse", {31'b0, bus.rvalid0}, 32'h0);
    checkEq("rd_rdata0_hold", bus.rdata0, 32'hDEAD_BEEF);

    // ---- both clients write continuously from reset: grants alternate from client 0
    resetPulse();
    cyc();
    op0(1'b1, 4'd1, 32'h11);
    op1(1'b1, 4'd2, 32'h22);
    for (int i = 0; i < 6; i++) begin
      #1;
      checkEq($sformatf("alt_gnt0_%0d", i), {31'b0, bus.gnt0}, (i % 2 == 0) ? 32'h1 : 32'h0);
      checkEq($sformatf("alt_gnt1_%0d", i), {31'b0, bus.gnt1}, (i % 2 == 1) ? 32'h1 : 32'h0);
      cyc();
    end
    idle0();
    idle1();
    cyc();
    checkEq("alt_r1", rfMem[1], 32'h11);
    checkEq("alt_r2", rfMem[2], 32'h22);

    // ---- read and write of r7 in the same cycle: write-first forwarding
    op0(1'b0, 4'd7, 32'h0);
    op1(1'b1, 4'd7, 32'hCAFE_F00D);
    #1;
    checkEq("fwd_gnt0", {31'b0, bus.gnt0}, 32'h1);
    checkEq("fwd_gnt1", {31'b0, bus.gnt1}, 32'h1);
    cyc();
    idle0();
    idle1();
    checkEq("fwd_rvalid0", {31'b0, bus.rvalid0}, 32'h1);
    checkEq("fwd_rdata0", bus.rdata0, 32'hCAFE_F00D);
    checkEq("fwd_rvalid1", {31'b0, bus.rvalid1}, 32'h0);

    // ---- read r3 while the other client writes r4: no forwarding
    op0(1'b1, 4'd3, 32'h33);
    cyc();
    op1(1'b1, 4'd9, 32'h99);
    op0(1'b0, 4'd3, 32'h0);
    cyc();
    op1(1'b1, 4'd4, 32'h44);
    #1;
    checkEq("nofwd_gnt0", {31'b0, bus.gnt0}, 32'h1);
    checkEq("nofwd_gnt1", {31'b0, bus.gnt1}, 32'h1);
    cyc();
    idle0();
    idle1();
    checkEq("nofwd_rdata0", bus.rdata0, 32'h33);
    checkEq("nofwd_r4", rfMem[4], 32'h44);

    // ---- both clients read r9 for 4 cycles with the read pointer back at 0
    resetPulse();
    cyc();
    op0(1'b0, 4'd9, 32'h0);
    op1(1'b0, 4'd9, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkEq($sformatf("rr_gnt0_%0d", i), {31'b0, bus.gnt0}, (i % 2 == 0) ? 32'h1 : 32'h0);
      checkEq($sformatf("rr_gnt1_%0d", i), {31'b0, bus.gnt1}, (i % 2 == 1) ? 32'h1 : 32'h0);
      cyc();
      checkEq($sformatf("rr_rvalid0_%0d", i), {31'b0, bus.rvalid0}, (i % 2 == 0) ? 32'h1 : 32'h0);
      checkEq($sformatf("rr_rvalid1_%0d", i), {31'b0, bus.rvalid1}, (i % 2 == 1) ? 32'h1 : 32'h0);
      checkEq($sformatf("rr_rdata_%0d", i), (i % 2 == 0) ? bus.rdata0 : bus.rdata1, 32'h99);
    end
    // write pointer untouched by the reads: contended write goes to client 0
    op0(1'b1, 4'd10, 32'hA0);
    op1(1'b1, 4'd11, 32'hB0);
    #1;
    checkEq("rr_wrptr_gnt0", {31'b0, bus.gnt0}, 32'h1);
    checkEq("rr_wrptr_gnt1", {31'b0, bus.gnt1}, 32'h0);
    cyc();
    idle0();
    idle1();
    checkEq("rr_rvalid0_end", {31'b0, bus.rvalid0}, 32'h0);

    // ---- async reset during a granted read; both pointers are at 1 beforehand
    op0(1'b0, 4'd9, 32'h0);
    cyc();
    idle0();
    op1(1'b0, 4'd9, 32'h0);
    #1;
    checkEq("ar_gnt1_before", {31'b0, bus.gnt1}, 32'h1);
    #2 reset = 1'b1;
    #1;
    checkEq("ar_gnt1_during", {31'b0, bus.gnt1}, 32'h0);
    checkEq("ar_rdata1_cleared", bus.rdata1, 32'h0);
    cyc();
    checkEq("ar_rvalid1", {31'b0, bus.rvalid1}, 32'h0);
    reset = 1'b0;
    idle1();
    op0(1'b1, 4'd12, 32'h1);
    op1(1'b1, 4'd13, 32'h2);
    #1;
    checkEq("ar_wr_gnt0", {31'b0, bus.gnt0}, 32'h1);
    checkEq("ar_wr_gnt1", {31'b0, bus.gnt1}, 32'h0);
    cyc();
    checkEq("ar_rvalid1_after", {31'b0, bus.rvalid1}, 32'h0);
    op0(1'b0, 4'd12, 32'h0);
    op1(1'b0, 4'd13, 32'h0);
    #1;
    checkEq("ar_rd_gnt0", {31'b0, bus.gnt0}, 32'h1);
    checkEq("ar_rd_gnt1", {31'b0, bus.gnt1}, 32'h0);
    cyc();
    idle0();
    idle1();
    checkEq("ar_rd_rdata0", bus.rdata0, 32'h1);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
